prog_loader: RTL and testbench
==============================

# prog_loader

Program loader upstream of `singlecycle`. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive word addresses from a programmable base. While loading, it holds the processor in reset. After the last word it drives the processor's `startpc` and releases the processor's active-low `resetl`. It lets a bench or host run several programs back to back without re-elaborating memory.

## Interface
- `MAX_WORDS`, 64: instruction-memory capacity in 32-bit words (power of two).
- `RST_CYCLES`, 2: cycles `cpu_resetl` stays low after the last write (≥1).
- `CLK` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE immediately.
- `load_start` in 1: one-cycle request to begin a load.
- `load_base` in 64: byte address of the first word, sampled with `load_start`; bits [1:0] ignored (forced 0).
- `in_valid` in 1: `in_data` / `in_last` valid.
- `in_data` in 32: instruction word.
- `in_last` in 1: marks the final word of the program.
- `in_ready` out 1: loader accepts a word this cycle.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out 64: byte address of the write.
- `imem_wdata` out 32: write data.
- `cpu_resetl` out 1: active-low reset to `singlecycle`.
- `startpc` out 64: start PC to `singlecycle`, equal to the captured base.
- `busy` out 1: high in LOAD or SETTLE.
- `done` out 1: high in RUN.
- `err_overflow` out 1: sticky; set when more than `MAX_WORDS` words are offered in one load.
- `word_count` out 7: words written in the current or last load (saturates at `MAX_WORDS`).

## Operation
- States: IDLE, LOAD, SETTLE, RUN.
- Reset value of every output is 0; `startpc` is 0.
- IDLE:
  - `cpu_resetl` = 0, `in_ready` = 0.
  - `load_start` → LOAD.
- Entry to LOAD (from IDLE or RUN):
  - capture `base` = {`load_base`[63:2],2'b00};
  - clear `word_count` and `err_overflow`;
  - drive `cpu_resetl` low.
- LOAD:
  - `in_ready` = 1.
  - A handshake is `in_valid` & `in_ready`.
  - On each handshake with `word_count` < `MAX_WORDS`: schedule write of `in_data` at `base` + 4·`word_count`, then increment `word_count`.
  - On a handshake with `word_count` == `MAX_WORDS`: discard the word and set `err_overflow`; no write.
  - A handshake with `in_last` = 1 → SETTLE, whether or not that word was written.
  - `load_start` is ignored in LOAD and SETTLE.
- SETTLE:
  - `in_ready` = 0, `cpu_resetl` = 0.
  - Counts `RST_CYCLES` cycles, then → RUN.
- RUN:
  - `cpu_resetl` = 1, `done` = 1, `startpc` = `base`.
  - `load_start` → LOAD, which re-asserts processor reset in the next cycle.
- `startpc` is held at `base` from LOAD entry onward, so it is stable for the whole reset window.
- Address arithmetic: 64-bit, wraps modulo 2^64 with no error.

## Timing
- Writes are registered: `imem_we`, `imem_addr`, `imem_wdata` are asserted the cycle after the handshake, for exactly one cycle per accepted word.
- Throughput is one word per cycle; `in_ready` stays high through all of LOAD.
- The last word's write occurs in the first SETTLE cycle, so it always precedes processor release (`RST_CYCLES` ≥ 1).
- `load_start` sampled at edge T (IDLE or RUN):
  - edge T+1: state is LOAD, `cpu_resetl` = 0, `in_ready` = 1;
  - first handshake possible at edge T+1.
- Last handshake at edge L:
  - SETTLE spans L+1 .. L+`RST_CYCLES`;
  - `cpu_resetl` rises and `done` = 1 after edge L+`RST_CYCLES`+1.
  - With default `RST_CYCLES`, processor reset is low for at least two posedges after the final write.
- Asynchronous `reset` mid-load:
  - all outputs drop to 0 at once, including `cpu_resetl`, which keeps the processor in reset;
  - the pending write is cancelled;
  - loading resumes only after a new `load_start`.
- `in_valid` with `in_last` in IDLE, SETTLE or RUN: no handshake, ignored.

## Test plan
- **Reset**: assert `reset` → all outputs 0, state IDLE; a word with `in_valid` = 1 → `in_ready` stays 0 and no `imem_we`.
- **Program 1**: `load_base` = 0, stream 13 words, last flagged →
  - 13 writes at 0x0..0x30 in order, one per cycle;
  - `word_count` = 13;
  - `cpu_resetl` rises exactly `RST_CYCLES`+1 edges after the last handshake;
  - `startpc` = 0.
- **Reload from RUN**: after Program 1 completes, `load_start` with `load_base` = 0x34 and 10 words → `cpu_resetl` low the cycle after; writes at 0x34..0x58; `startpc` = 0x34.
- **Backpressure gaps**: `in_valid` toggled 1,0,0,1,1 → exactly 3 writes with consecutive addresses and no duplicates.
- **Overflow**: `MAX_WORDS` = 64, stream 66 words →
  - 64 writes (0x0..0xFC);
  - `err_overflow` = 1, `word_count` = 64;
  - still reaches RUN.
- **Reset mid-load**: assert `reset` after 5 handshakes → no further `imem_we`, `cpu_resetl` stays 0, `done` = 0 until a new load completes.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: streams instruction words into imem from a programmable
// base while holding the processor in reset, then releases it at startpc.
module prog_loader #(
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        load_start,
  input  logic [63:0] load_base,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_resetl,
  output logic [63:0] startpc,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic [6:0]  word_count
);

  localparam int unsigned WC_W = 7;
  localparam int unsigned SC_W = $clog2(RST_CYCLES + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [SC_W-1:0] settle_cnt;
  logic [SC_W-1:0] settle_d;
  logic            load_enter;
  logic            wr_en;
  logic            ovf_set;
  logic            hs;

  // State and settle-counter registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_d;
    end
  end

  // Next-state decode plus per-cycle load/write/overflow decisions
  always_comb begin
    state_d    = state;
    settle_d   = settle_cnt;
    load_enter = 1'b0;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    hs         = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          load_enter = 1'b1;
        end
      end
      S_LOAD: begin
        hs = in_valid & in_ready;
        if (hs) begin
          if (word_count < WC_W'(MAX_WORDS)) begin
            wr_en = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
          if (in_last) begin
            state_d  = S_SETTLE;
            settle_d = '0;
          end
        end
      end
      S_SETTLE: begin
        // Hold reset for RST_CYCLES cycles after the final write lands
        if (settle_cnt == SC_W'(RST_CYCLES)) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_cnt + SC_W'(1);
        end
      end
      S_RUN: begin
        if (load_start) begin
          state_d    = S_LOAD;
          load_enter = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs, write port and load bookkeeping
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cpu_resetl   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      startpc      <= '0;
      word_count   <= '0;
      err_overflow <= 1'b0;
    end else begin
      in_ready   <= (state_d == S_LOAD);
      busy       <= (state_d == S_LOAD) || (state_d == S_SETTLE);
      done       <= (state_d == S_RUN);
      cpu_resetl <= (state_d == S_RUN);
      imem_we    <= wr_en;
      if (wr_en) begin
        imem_addr  <= startpc + (64'(word_count) << 2);
        imem_wdata <= in_data;
      end
      if (load_enter) begin
        startpc      <= load_base & ~64'h3;
        word_count   <= '0;
        err_overflow <= 1'b0;
      end else begin
        if (wr_en) begin
          word_count <= word_count + WC_W'(1);
        end
        if (ovf_set) begin
          err_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, reloads, gaps, overflow, wrap, resets.
module tb_prog_loader;

  localparam int unsigned MAX_WORDS  = 64;
  localparam int unsigned RST_CYCLES = 2;

  logic        CLK = 1'b0;
  logic        reset;
  logic        load_start;
  logic [63:0] load_base;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_resetl;
  logic [63:0] startpc;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic [6:0]  word_count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t wq[$];

  prog_loader #(.MAX_WORDS(MAX_WORDS), .RST_CYCLES(RST_CYCLES)) dut (
    .CLK(CLK), .reset(reset), .load_start(load_start), .load_base(load_base),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_resetl(cpu_resetl), .startpc(startpc),
    .busy(busy), .done(done), .err_overflow(err_overflow),
    .word_count(word_count)
  );

  always #5 CLK = ~CLK;

  // Cycle counter and write monitor (writes last exactly one cycle)
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (imem_we) wq.push_back('{a: imem_addr, d: imem_wdata, c: cyc});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_load(input logic [63:0] base);
    load_start = 1'b1;
    load_base  = base;
    @(negedge CLK);
    load_start = 1'b0;
    load_base  = 64'h5555_5555_5555_5555;
    check("entry_in_ready", {63'b0, in_ready}, 64'd1);
    check("entry_resetl", {63'b0, cpu_resetl}, 64'd0);
    check("entry_done", {63'b0, done}, 64'd0);
    check("entry_startpc", startpc, base & ~64'h3);
  endtask

  // vmask bit c selects whether cycle c offers a word (cycles >= 32 always do)
  task automatic send_words(input int n_cyc, input logic [31:0] tag,
                            input logic [31:0] vmask, input bit with_last);
    int k = 0;
    logic v;
    for (int c = 0; c < n_cyc; c++) begin
      v = (c < 32) ? vmask[c[4:0]] : 1'b1;
      in_valid = v;
      in_data  = v ? tag + 32'(k) : 32'hDEAD_0000 + 32'(c);
      in_last  = with_last && (c == n_cyc - 1);
      if (v) k++;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called at the negedge right after the last handshake
  task automatic check_release(input logic [63:0] base);
    for (int k = 0; k <= int'(RST_CYCLES); k++) begin
      check($sformatf("settle_resetl[%0d]", k), {63'b0, cpu_resetl}, 64'd0);
      check($sformatf("settle_done[%0d]", k), {63'b0, done}, 64'd0);
      @(negedge CLK);
    end
    check("run_resetl", {63'b0, cpu_resetl}, 64'd1);
    check("run_done", {63'b0, done}, 64'd1);
    check("run_busy", {63'b0, busy}, 64'd0);
    check("run_startpc", startpc, base);
  endtask

  task automatic check_writes(input logic [63:0] base, input logic [31:0] tag,
                              input int n, input bit back2back);
    check("wr_count", 64'(wq.size()), 64'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      check($sformatf("wr_addr[%0d]", k), wq[k].a, base + 64'(4 * k));
      check($sformatf("wr_data[%0d]", k), {32'b0, wq[k].d}, {32'b0, tag + 32'(k)});
      if (back2back) check($sformatf("wr_cyc[%0d]", k), 64'(wq[k].c - wq[0].c), 64'(k));
    end
    wq.delete();
  endtask

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    in_valid   = 1'b1;
    in_data    = 32'h1234_5678;
    in_last    = 1'b1;
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_we", {63'b0, imem_we}, 64'd0);
    check("rst_resetl", {63'b0, cpu_resetl}, 64'd0);
    check("rst_startpc", startpc, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_ovf", {63'b0, err_overflow}, 64'd0);
    check("rst_wc", {57'b0, word_count}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    // Words offered in IDLE must be ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("idle_in_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_writes(64'h0, 32'h0, 0, 1'b0);

    // Program 1: 13 words from address 0
    start_load(64'h0);
    send_words(13, 32'hA100_0000, 32'hFFFF_FFFF, 1'b1);
    check_release(64'h0);
    check("p1_wc", {57'b0, word_count}, 64'd13);
    check_writes(64'h0, 32'hA100_0000, 13, 1'b1);

    // Reload from RUN at 0x34, 10 words
    start_load(64'h34);
    check("p2_busy", {63'b0, busy}, 64'd1);
    send_words(10, 32'hB200_0000, 32'hFFFF_FFFF, 1'b1);
    check_release(64'h34);
    check("p2_wc", {57'b0, word_count}, 64'd10);
    check_writes(64'h34, 32'hB200_0000, 10, 1'b1);

    // Backpressure gaps 1,0,0,1,1; low base bits must be dropped
    start_load(64'h203);
    send_words(5, 32'hC300_0000, 32'h0000_0019, 1'b1);
    check_release(64'h200);
    check("gap_wc", {57'b0, word_count}, 64'd3);
    check_writes(64'h200, 32'hC300_0000, 3, 1'b0);

    // Overflow: 66 words into a 64-word memory
    start_load(64'h0);
    send_words(66, 32'hD400_0000, 32'hFFFF_FFFF, 1'b1);
    check_release(64'h0);
    check("ovf_flag", {63'b0, err_overflow}, 64'd1);
    check("ovf_wc", {57'b0, word_count}, 64'd64);
    check_writes(64'h0, 32'hD400_0000, 64, 1'b1);

    // Address wrap past 2^64
    start_load(64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap_ovf_clr", {63'b0, err_overflow}, 64'd0);
    send_words(3, 32'hE500_0000, 32'hFFFF_FFFF, 1'b1);
    check_release(64'hFFFF_FFFF_FFFF_FFF8);
    check_writes(64'hFFFF_FFFF_FFFF_FFF8, 32'hE500_0000, 3, 1'b1);

    // Reset mid-load after 5 handshakes
    start_load(64'h100);
    send_words(5, 32'hF600_0000, 32'hFFFF_FFFF, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h0BAD_0BAD;
    #2 reset = 1'b1;
    #1;
    check("mid_we", {63'b0, imem_we}, 64'd0);
    check("mid_in_ready", {63'b0, in_ready}, 64'd0);
    check("mid_resetl", {63'b0, cpu_resetl}, 64'd0);
    check("mid_wc", {57'b0, word_count}, 64'd0);
    check("mid_busy", {63'b0, busy}, 64'd0);
    @(negedge CLK);
    reset   = 1'b0;
    in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_rst_ready", {63'b0, in_ready}, 64'd0);
      check("post_rst_resetl", {63'b0, cpu_resetl}, 64'd0);
      check("post_rst_done", {63'b0, done}, 64'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_writes(64'h100, 32'hF600_0000, 5, 1'b1);
    start_load(64'h400);
    send_words(2, 32'h1700_0000, 32'hFFFF_FFFF, 1'b1);
    check_release(64'h400);
    check_writes(64'h400, 32'h1700_0000, 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
